// File: rtl/fib_pkg.sv
// Shared constants and FSM state encoding for the Fibonacci term scheduler.
package fib_pkg;

  localparam int FIB_W   = 16;
  localparam int MAX_IDX = 24;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_id    = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fib_scheduler.sv
// Shares one Fibonacci generator among NREQ clients; returns F(n) per request.
// Handshake: a client holds req[i] (and a stable index) until it sees ack[i]; ack is a one-cycle pulse with rsp_valid.
module fib_scheduler
  import fib_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDX_W   = 5,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*IDX_W-1:0] req_idx,
  output logic [NREQ-1:0]       ack,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [FIB_W-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  gen_rst,
  output logic                  gen_en,
  input  logic                  gen_valid,
  input  logic [FIB_W-1:0]      gen_out,
  output logic [1:0]            dbg_state
);

  localparam int TO_W = $clog2(TIMEOUT);

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] term_cnt;
  logic [TO_W-1:0]  to_cnt;

  logic [NREQ-1:0]  arb_grant;
  logic [ID_W-1:0]  arb_id;
  logic             arb_any;
  logic [IDX_W-1:0] arb_idx;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req      (req),
    .ptr      (ptr),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .any      (arb_any)
  );

  assign arb_idx   = req_idx[arb_id*IDX_W +: IDX_W];
  assign gen_en    = (state == ST_RUN);
  assign gen_rst   = (state != ST_RUN);
  assign dbg_state = state;

  // Response fields are loaded on the edge entering RESP so they are valid with the strobe and then held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      grant_q   <= '0;
      idx_q     <= '0;
      term_cnt  <= '0;
      to_cnt    <= '0;
      ack       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant_q <= arb_id;
            idx_q   <= arb_idx;
            if (int'(arb_idx) > MAX_IDX) begin
              state     <= ST_RESP;
              ack       <= arb_grant;
              rsp_valid <= 1'b1;
              rsp_id    <= arb_id;
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
            end else begin
              state <= ST_CLR;
            end
          end
        end
        ST_CLR: begin
          term_cnt <= '0;
          to_cnt   <= '0;
          state    <= ST_RUN;
        end
        ST_RUN: begin
          if (gen_valid) begin
            if (term_cnt == idx_q) begin
              state     <= ST_RESP;
              ack       <= NREQ'(1) << grant_q;
              rsp_valid <= 1'b1;
              rsp_id    <= grant_q;
              rsp_data  <= gen_out;
              rsp_err   <= 1'b0;
            end else begin
              term_cnt <= term_cnt + 1'b1;
              to_cnt   <= '0;
            end
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            state     <= ST_RESP;
            ack       <= NREQ'(1) << grant_q;
            rsp_valid <= 1'b1;
            rsp_id    <= grant_q;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          ack       <= '0;
          rsp_valid <= 1'b0;
          ptr       <= (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_scheduler.sv
// Bench for fib_scheduler with a behavioural Fibonacci generator (always-valid, never-valid or random stalls).
module tb_fib_scheduler;
  import fib_pkg::*;

  localparam int NREQ    = 4;
  localparam int IDX_W   = 5;
  localparam int TIMEOUT = 64;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + 1 + FIB_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*IDX_W-1:0] req_idx = '0;
  logic [NREQ-1:0]       ack;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [FIB_W-1:0]      rsp_data;
  logic                  rsp_err;
  logic                  gen_rst;
  logic                  gen_en;
  logic                  gen_valid;
  logic [FIB_W-1:0]      gen_out;
  logic [1:0]            dbg_state;

  fib_scheduler #(.NREQ(NREQ), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_idx   (req_idx),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .gen_rst   (gen_rst),
    .gen_en    (gen_en),
    .gen_valid (gen_valid),
    .gen_out   (gen_out),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- generator model ----------------
  int             gen_mode = 1;  // 0: never valid, 1: always valid, 2: random stalls
  logic           coin = 1'b0;
  logic [15:0]    fa = '0;
  logic [15:0]    fb = 16'd1;
  int             gen_en_cnt = 0;

  assign gen_valid = gen_en && ((gen_mode == 1) || (gen_mode == 2 && coin));
  assign gen_out   = fa;

  always @(posedge clk) begin
    coin <= 1'($urandom_range(0, 1));
    if (gen_en) gen_en_cnt <= gen_en_cnt + 1;
    if (gen_rst) begin
      fa <= 16'd0;
      fb <= 16'd1;
    end else if (gen_valid) begin
      fa <= fb;
      fb <= fa + fb;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [W-1:0] mk(input int id, input bit err, input int data);
    return {ID_W'(id), err, FIB_W'(data)};
  endfunction

  function automatic logic [W-1:0] ref_rsp(input int id, input int n);
    int a, b, t;
    if (n > MAX_IDX) return mk(id, 1'b1, 0);
    a = 0; b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b; a = b; b = t;
    end
    return mk(id, 1'b0, a);
  endfunction

  // Every strobe must be a single ack bit, coincident with rsp_valid, in RESP.
  always @(negedge clk) begin
    if (rst && (rsp_valid || ack != '0))
      check("ack_strobe", {31'd0, rsp_valid && $onehot(ack) && (dbg_state == ST_RESP)}, 32'd1);
  end

  // Wait for the next response, compare it with the queue head; exp_lat <= 0 skips the latency check.
  task automatic wait_rsp(input string tag, input int exp_lat);
    int c;
    logic [W-1:0] e;
    logic [NREQ-1:0] e_ack;
    c = 0;
    while (c < 300 && !rsp_valid) begin
      @(posedge clk); #1;
      c++;
    end
    if (!rsp_valid) begin
      n_checks++;
      $display("FAIL %s: no response within 300 cycles", tag);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: response %0h with empty expected queue", tag, {rsp_id, rsp_err, rsp_data});
      return;
    end
    e = exp_q.pop_front();
    e_ack = NREQ'(1) << e[W-1 -: ID_W];
    check({tag, "_id"},   rsp_id,   e[W-1 -: ID_W]);
    check({tag, "_err"},  rsp_err,  e[FIB_W]);
    check({tag, "_data"}, rsp_data, e[FIB_W-1:0]);
    check({tag, "_ack"},  ack,      e_ack);
    if (exp_lat > 0) check({tag, "_lat"}, c, exp_lat);
  endtask

  task automatic serve(input int client, input int idx, input logic [W-1:0] e, input int exp_lat, input string tag);
    @(posedge clk); #1;
    req_idx[client*IDX_W +: IDX_W] = IDX_W'(idx);
    req[client] = 1'b1;
    exp_q.push_back(e);
    wait_rsp(tag, exp_lat);
    req[client] = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int client;
    int idx;
    int exp_data;
    bit exp_err;
    int exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int en0;
    int prev;
    int fair_idx[4];

    vecs[0] = '{0, 10,    55, 1'b0, 13};
    vecs[1] = '{1,  0,     0, 1'b0,  3};
    vecs[2] = '{2,  1,     1, 1'b0,  4};
    vecs[3] = '{3, 24, 46368, 1'b0, 27};
    vecs[4] = '{0, 25,     0, 1'b1,  1};
    vecs[5] = '{1, 31,     0, 1'b1,  1};
    vecs[6] = '{2,  2,     1, 1'b0,  5};
    vecs[7] = '{3, 12,   144, 1'b0, 15};

    // reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_gen_en", gen_en, 0);
    check("rst_gen_rst", gen_rst, 1);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b1;

    // single requests incl. boundary indices
    gen_mode = 1;
    foreach (vecs[i]) begin
      en0 = gen_en_cnt;
      serve(vecs[i].client, vecs[i].idx, mk(vecs[i].client, vecs[i].exp_err, vecs[i].exp_data),
            vecs[i].exp_lat, $sformatf("vec%0d", i));
      if (vecs[i].exp_err) check($sformatf("vec%0d_no_gen_en", i), gen_en_cnt - en0, 0);
    end

    // fairness: all four hold req; pointer is 0 after client 3 was last served
    fair_idx = '{2, 5, 7, 9};
    for (int c = 0; c < NREQ; c++) req_idx[c*IDX_W +: IDX_W] = IDX_W'(fair_idx[c]);
    for (int r = 0; r < 8; r++) exp_q.push_back(ref_rsp(r % NREQ, fair_idx[r % NREQ]));
    @(posedge clk); #1;
    req = '1;
    prev = -1;
    for (int r = 0; r < 8; r++) begin
      wait_rsp($sformatf("fair%0d", r), 0);
      check($sformatf("fair%0d_no_repeat", r), {31'd0, int'(rsp_id) != prev}, 1);
      prev = int'(rsp_id);
      if (r < 7) begin @(posedge clk); #1; end
    end
    req = '0;

    // client drops req mid-service: ack still pulsed
    @(posedge clk); #1;
    req_idx[0 +: IDX_W] = IDX_W'(15);
    req[0] = 1'b1;
    exp_q.push_back(mk(0, 1'b0, 610));
    repeat (5) @(posedge clk);
    #1;
    req[0] = 1'b0;
    wait_rsp("drop", 0);

    // generator timeout, then normal service
    gen_mode = 0;
    serve(2, 5, mk(2, 1'b1, 0), 66, "timeout");
    gen_mode = 1;
    serve(1, 7, mk(1, 1'b0, 13), 10, "after_to");
    repeat (3) @(posedge clk);
    #1;
    check("hold_data", rsp_data, 13);
    check("hold_id", rsp_id, 1);
    check("hold_valid", rsp_valid, 0);

    // random stalls and indices
    gen_mode = 2;
    for (int r = 0; r < 4; r++) begin
      int cl, ix;
      cl = $urandom_range(0, NREQ - 1);
      ix = $urandom_range(0, MAX_IDX);
      serve(cl, ix, ref_rsp(cl, ix), 0, $sformatf("rand%0d", r));
    end
    gen_mode = 1;

    // reset asserted mid-RUN, held request re-served afterwards
    @(posedge clk); #1;
    req_idx[3*IDX_W +: IDX_W] = IDX_W'(20);
    req[3] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrun_state", dbg_state, ST_RUN);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_ack", ack, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_data", rsp_data, 0);
    check("midrst_rsp_id", rsp_id, 0);
    check("midrst_gen_en", gen_en, 0);
    check("midrst_gen_rst", gen_rst, 1);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_ack", ack, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    rst = 1'b1;
    exp_q.push_back(mk(3, 1'b0, 6765));
    wait_rsp("post_rst", 23);
    req[3] = 1'b0;

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fib_scheduler.md
Name: fib_scheduler

Overview:
- Shares one `fibonacci` generator (16-bit, `f_en`/`f_valid`/`f_out` stream) among NREQ requesters.
- Each requester asks for term F(n). The scheduler arbitrates round-robin, clears the generator, and enables it. It counts valid terms, captures term n and returns it with a one-cycle response/ack.
- Sits between the requester clients and the generator instance in the datapath top.

Parameters:
- NREQ, 4, number of requesters.
- IDX_W, 5, width of each requested index.
- MAX_IDX, 24, largest legal index (F(24)=46368; F(25) overflows 16 bits).
- TIMEOUT, 64, max cycles in RUN between consecutive `gen_valid` pulses before error.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req  in  NREQ  request per client; held high until matching ack bit
- req_idx  in  NREQ*IDX_W  packed indices; client i at [i*IDX_W +: IDX_W], stable while req[i]=1
- ack  out  NREQ  one-hot, one-cycle pulse to the served client
- rsp_valid  out  1  one-cycle response strobe, coincident with ack
- rsp_id  out  clog2(NREQ)  served client number
- rsp_data  out  16  F(n); 0 on error
- rsp_err  out  1  index out of range or generator timeout
- gen_rst  out  1  active-high clear to generator `rst`
- gen_en  out  1  generator `f_en`
- gen_valid  in  1  generator `f_valid`
- gen_out  in  16  generator `f_out`

Behaviour:
- Reset values: `ack`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `gen_en`=0, `gen_rst`=1. Round-robin pointer=0, term counter=0, timeout counter=0, state=IDLE.
- Generator contract: after `gen_rst` is held for one cycle and `gen_en` is high, each `gen_valid`=1 cycle presents the next term F(0)=0, F(1)=1, F(2)=1, ….
- FSM states: IDLE, CLR, RUN, RESP.
- IDLE:
  - `gen_rst`=1, `gen_en`=0.
  - If any `req` is set, latch `grant` = first set bit at or after the pointer (wrapping) and latch its idx.
  - If idx > MAX_IDX, go to RESP with err=1. Otherwise go to CLR.
- CLR: exactly one cycle, `gen_rst`=1, `gen_en`=0. Clears term counter and timeout counter. Next state RUN.
- RUN:
  - `gen_rst`=0, `gen_en`=1.
  - On `gen_valid`: if term counter == idx, capture `gen_out`, go to RESP with err=0; else increment term counter and clear the timeout counter.
  - Without `gen_valid`: increment the timeout counter. When it reaches TIMEOUT-1, go to RESP with err=1 and data=0.
- RESP:
  - One cycle, `gen_en`=0, `gen_rst`=1.
  - `rsp_valid`=1, `ack[grant]`=1, `rsp_id`=grant, `rsp_data`/`rsp_err` as captured.
  - Pointer = grant+1 mod NREQ. Next state IDLE.
- `rsp_data`, `rsp_id` and `rsp_err` hold their values after the strobe until the next RESP.
- Latency, legal idx n with a generator that is valid every cycle: request seen in IDLE → RESP is 1 (CLR) + (n+1) (RUN) + 1 cycles. `rsp_valid` is asserted n+3 cycles after the IDLE sample edge.
- Out-of-range idx: `rsp_valid` is asserted 1 cycle after the IDLE sample edge.
- Requests arriving while busy wait; there is no queue beyond `req` being held.
- Client drops `req` mid-service: service completes and ack is still pulsed; the client ignores it.
- Simultaneous requests: strict round-robin from the pointer. A client re-requesting right after ack waits behind the others that are pending.
- Reset asserted mid-RUN: immediate return to reset values. No response is issued, and `gen_rst`=1 clears the generator.
- idx=0 is served by the first `gen_valid`, data=0.
- Only one ack bit is ever high, and only in RESP.

Decomposition:
- Shared package `fib_pkg`:
  - constants FIB_W=16 and MAX_IDX=24.
  - state encoding for IDLE/CLR/RUN/RESP.
- One natural sub-module, `rr_arbiter` (NREQ requests, pointer input → one-hot grant plus index, combinational). The FSM and counters stay in `fib_scheduler`.

Test Plan:
- Single request: req[0]=1, idx=10, real generator → `rsp_valid` with `rsp_id`=0, `rsp_data`=55, `rsp_err`=0, ack=4'b0001 at n+3=13 cycles.
- Boundaries: idx=0 → data 0; idx=1 → 1; idx=24 → 46368, err=0; idx=25 → err=1, data=0, `rsp_valid` 1 cycle after the sample edge, `gen_en` never high.
- Fairness: req=4'b1111 held constantly, each client re-requesting after its ack → ack order 0,1,2,3,0,… with no client served twice in a row.
- Timeout: stub generator never asserts `gen_valid`, req[2]=1, idx=5 → after 64 RUN cycles `rsp_err`=1, `rsp_id`=2, data=0; next request is then served normally.
- Reset mid-RUN: drive `rst`=0 during RUN of idx=20 → all outputs at reset values immediately and no ack. After `rst`=1 the held req is re-served with data 6765.
